gonso_io_pattern_player: RTL and testbench

- Wishbone slave in the user project area. Firmware pushes 8-bit patterns into a small FIFO.
- Patterns are played onto mprj_io[7:0] in order, each held for a programmable number of clocks.
- The block sits directly upstream of the user I/O pads. It produces the mprj_io[7:0] values that the chip-level pepe bench waits on.

---
 rtl/gonso_pkg.sv | 36 +++
 rtl/gonso_sync_fifo.sv | 81 ++++++++
 rtl/gonso_io_pattern_player.sv | 186 ++++++++++++++++++
 tb/tb_gonso_io_pattern_player.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gonso_pkg.sv
// Shared definitions for the I/O pattern player: register offsets, field
// indices, the STATUS word layout and the playback FSM states.
package gonso_pkg;

  localparam logic [3:0] ADR_CTRL   = 4'h0;
  localparam logic [3:0] ADR_HOLD   = 4'h4;
  localparam logic [3:0] ADR_DATA   = 4'h8;
  localparam logic [3:0] ADR_STATUS = 4'hC;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_OE    = 1;
  localparam int unsigned CTRL_FLUSH = 2;

  localparam int unsigned ST_EMPTY = 5;
  localparam int unsigned ST_FULL  = 6;
  localparam int unsigned ST_BUSY  = 7;
  localparam int unsigned ST_OVF   = 8;

  localparam int unsigned LEVEL_W = 5;

  // Bit layout matches the ST_* indices above.
  typedef struct packed {
    logic [22:0]        rsvd;
    logic               overflow;
    logic               busy;
    logic               full;
    logic               empty;
    logic [LEVEL_W-1:0] level;
  } status_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

endpackage

// File: rtl/gonso_sync_fifo.sv
// Synchronous DEPTHxWIDTH FIFO with flush; a push into a full FIFO is
// accepted only when a pop happens in the same cycle, otherwise it is dropped.
module gonso_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        head_c_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    drop_c_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push_c, do_pop_c;

  // Flush beats both push and pop; full only blocks a push with no pop.
  always_comb begin
    do_pop_c  = pop_i & ~empty_q & ~flush_i;
    do_push_c = push_i & ~flush_i & (~full_q | do_pop_c);
    drop_c_o  = push_i & ~flush_i & full_q & ~do_pop_c;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign level_o  = level_q;

endmodule

// File: rtl/gonso_io_pattern_player.sv
// Wishbone-programmed pattern player: firmware queues 8-bit patterns that are
// replayed on mprj_io[7:0], each held for a programmable number of clocks.
module gonso_io_pattern_player
  import gonso_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned HOLD_W   = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  io_out,
  output logic [7:0]  io_oeb
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              ack_q;
  logic [31:0]       dat_q, dat_d;
  logic              en_q, en_d;
  logic              oe_q, oe_d;
  logic [7:0]        oeb_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ovf_q, ovf_d;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [7:0]        io_out_q, io_out_d;

  logic              req_c, wr_c, rd_c;
  logic [3:0]        off_c;
  logic              wr_ctrl_c, wr_hold_c, push_c, ovf_clr_c, flush_c, pop_c;
  logic [HOLD_W-1:0] reload_c;
  status_t           status_c;
  logic [31:0]       rdata_c;
  logic              unused_c;

  logic [7:0]        fifo_head_c;
  logic              fifo_full, fifo_empty, fifo_drop_c;
  logic [LVL_W-1:0]  fifo_level;

  gonso_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .push_i   (push_c),
    .pop_i    (pop_c),
    .flush_i  (flush_c),
    .wdata_i  (wbs_dat_i[7:0]),
    .head_c_o (fifo_head_c),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .level_o  (fifo_level),
    .drop_c_o (fifo_drop_c)
  );

  // Bus decode; the !ack term enforces the idle cycle between transfers.
  always_comb begin
    off_c     = wbs_adr_i[3:0];
    req_c     = wbs_cyc_i & wbs_stb_i & ~ack_q &
                (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    wr_c      = req_c & wbs_we_i;
    rd_c      = req_c & ~wbs_we_i;
    wr_ctrl_c = wr_c & (off_c == ADR_CTRL) & wbs_sel_i[0];
    wr_hold_c = wr_c & (off_c == ADR_HOLD);
    push_c    = wr_c & (off_c == ADR_DATA) & wbs_sel_i[0];
    ovf_clr_c = wr_c & (off_c == ADR_STATUS) & wbs_sel_i[0] & wbs_dat_i[ST_OVF];
    flush_c   = wr_ctrl_c & wbs_dat_i[CTRL_FLUSH];
    unused_c  = ^{wbs_sel_i, wbs_dat_i};
  end

  // Control registers; a drop in the same cycle as a clear keeps overflow set.
  always_comb begin
    en_d   = en_q;
    oe_d   = oe_q;
    hold_d = hold_q;
    ovf_d  = ovf_q;
    if (wr_ctrl_c) begin
      en_d = wbs_dat_i[CTRL_EN];
      oe_d = wbs_dat_i[CTRL_OE];
    end
    if (wr_hold_c)   hold_d = wbs_dat_i[HOLD_W-1:0];
    if (ovf_clr_c)   ovf_d  = 1'b0;
    if (fifo_drop_c) ovf_d  = 1'b1;
  end

  always_comb begin
    status_c          = '0;
    status_c.level    = LEVEL_W'(fifo_level);
    status_c.empty    = fifo_empty;
    status_c.full     = fifo_full;
    status_c.busy     = (state_q != IDLE);
    status_c.overflow = ovf_q;
    rdata_c           = '0;
    case (off_c)
      ADR_CTRL: begin
        rdata_c[CTRL_EN] = en_q;
        rdata_c[CTRL_OE] = oe_q;
      end
      ADR_HOLD:   rdata_c = 32'(hold_q);
      ADR_STATUS: rdata_c = status_c;
      default:    rdata_c = '0;
    endcase
    dat_d = rd_c ? rdata_c : '0;
  end

  // Playback FSM; reload value is max(HOLD,1)-1 so HOLD=0 plays as one clock.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    io_out_d = io_out_q;
    pop_c    = 1'b0;
    reload_c = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);
    case (state_q)
      IDLE: begin
        if (en_q && !fifo_empty) begin
          pop_c    = 1'b1;
          io_out_d = fifo_head_c;
          cnt_d    = reload_c;
          state_d  = SHOW;
        end
      end
      SHOW: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (!fifo_empty) begin
          pop_c    = 1'b1;
          io_out_d = fifo_head_c;
          cnt_d    = reload_c;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_c) begin
      state_d  = IDLE;
      pop_c    = 1'b0;
      cnt_d    = cnt_q;
      io_out_d = io_out_q;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      en_q     <= 1'b0;
      oe_q     <= 1'b0;
      oeb_q    <= 8'hFF;
      hold_q   <= HOLD_W'(1);
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      io_out_q <= 8'h00;
    end else begin
      ack_q    <= req_c;
      dat_q    <= dat_d;
      en_q     <= en_d;
      oe_q     <= oe_d;
      oeb_q    <= oe_q ? 8'h00 : 8'hFF;
      hold_q   <= hold_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      io_out_q <= io_out_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = io_out_q;
  assign io_oeb    = oeb_q;

endmodule

// File: tb/tb_gonso_io_pattern_player.sv
// Scoreboard bench for gonso_io_pattern_player: expected pad patterns are
// queued as DATA writes are issued and checked as io_out changes.
module tb_gonso_io_pattern_player;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_HOLD = BASE + 32'h4;
  localparam logic [31:0] A_DATA = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  io_out, io_oeb;

  int unsigned cyc_cnt = 0;
  int          n_chk   = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];

  gonso_io_pattern_player dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_out    (io_out),
    .io_oeb    (io_oeb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Returns at the negedge after the sampling edge; e0 is that edge's cycle index.
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int unsigned e0);
    int unsigned extra;
    bit          got;
    got   = 1'b0;
    extra = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin got = 1'b1; break; end
      extra++;
    end
    e0  = cyc_cnt;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    n_chk++;
    if (!got || extra != 0) begin
      n_fail++;
      $display("FAIL wb_write_ack adr=%08h: got=%0b after %0d extra cycles, required ack on first cycle",
               a, got, extra);
    end
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    int unsigned extra;
    bit          got;
    got   = 1'b0;
    extra = 0;
    d     = 32'hDEAD_BEEF;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin got = 1'b1; d = rdat; break; end
      extra++;
    end
    cyc = 1'b0; stb = 1'b0;
    n_chk++;
    if (!got || extra != 0) begin
      n_fail++;
      $display("FAIL wb_read_ack adr=%08h: got=%0b after %0d extra cycles, required ack on first cycle",
               a, got, extra);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (io_out !== 8'h00) begin n_fail++; $display("FAIL reset_io_out: got %02h, required 00", io_out); end
    n_chk++; if (io_oeb !== 8'hFF) begin n_fail++; $display("FAIL reset_io_oeb: got %02h, required FF", io_oeb); end
    n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b, required 0", ack); end
    n_chk++; if (rdat !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %08h, required 0", rdat); end
    rst = 1'b0;
    wb_read(A_STAT, r);
    n_chk++; if (r !== 32'h20) begin n_fail++; $display("FAIL reset_status: got %08h, required 00000020", r); end
  endtask

  task automatic test_single();
    int unsigned e0, ign;
    logic [31:0] r;
    logic [7:0]  exp_v;
    bit          seen;
    wb_write(A_CTRL, 32'h3, 4'h1, ign);
    wb_write(A_HOLD, 32'h0, 4'hF, ign);
    // Out-of-window access aliasing CTRL offset must be ignored.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h10; wdat = 32'h0; sel = 4'hF;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (ack !== 1'b0) seen = 1'b1; end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL nomatch_ack: got ack=1, required no ack"); end
    exp_q.push_back(8'h9A);
    wb_write(A_DATA, 32'h29A, 4'hF, e0);
    n_chk++; if (io_out !== 8'h00) begin n_fail++; $display("FAIL single_early: got %02h at E0, required 00", io_out); end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_chk++; if (io_out !== exp_v) begin n_fail++; $display("FAIL single_latency: got %02h at E0+1, required %02h", io_out, exp_v); end
    n_chk++; if (io_oeb !== 8'h00) begin n_fail++; $display("FAIL single_oeb: got %02h, required 00", io_oeb); end
    wb_write(A_DATA, 32'h55, 4'hE, ign);
    wb_read(A_STAT, r);
    n_chk++; if (r !== 32'h20) begin n_fail++; $display("FAIL sel0_nopush_status: got %08h, required 00000020", r); end
    n_chk++; if (io_out !== 8'h9A) begin n_fail++; $display("FAIL single_hold_last: got %02h, required 9A", io_out); end
  endtask

  task automatic test_back_to_back();
    int unsigned e0, ign;
    logic [31:0] r;
    logic [7:0]  prev, exp_v;
    bit          got;
    wb_write(A_CTRL, 32'h2, 4'h1, ign);
    wb_write(A_HOLD, 32'd4, 4'hF, ign);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(8'(8'h11 * (k + 1)));
      wb_write(A_DATA, 32'(8'h11 * (k + 1)), 4'h1, ign);
    end
    wb_write(A_CTRL, 32'h3, 4'h1, e0);
    prev = io_out;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (io_out !== prev) begin got = 1'b1; break; end
      end
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL b2b_timeout: pattern %0d never appeared, io_out stuck at %02h", k, io_out); break; end
      prev  = io_out;
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      if (io_out !== exp_v) begin n_fail++; $display("FAIL b2b_value: got %02h, required %02h", io_out, exp_v); end
      n_chk++;
      if (cyc_cnt != e0 + 1 + 4 * k) begin
        n_fail++;
        $display("FAIL b2b_time: pattern %0d at cycle %0d, required %0d", k, cyc_cnt, e0 + 1 + 4 * k);
      end
    end
    repeat (6) @(negedge clk);
    n_chk++; if (io_out !== 8'h33) begin n_fail++; $display("FAIL b2b_hold_last: got %02h, required 33", io_out); end
    wb_read(A_STAT, r);
    n_chk++; if (r !== 32'h20) begin n_fail++; $display("FAIL b2b_idle_status: got %08h, required 00000020", r); end
  endtask

  task automatic test_overflow();
    int unsigned ign;
    logic [31:0] r;
    wb_write(A_CTRL, 32'h2, 4'h1, ign);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(8'(8'h40 + i));
      wb_write(A_DATA, 32'(8'h40 + i), 4'h1, ign);
    end
    wb_read(A_STAT, r);
    n_chk++; if (r !== 32'h148) begin n_fail++; $display("FAIL ovf_status: got %08h, required 00000148", r); end
    wb_write(A_STAT, 32'h100, 4'h3, ign);
    wb_read(A_STAT, r);
    n_chk++; if (r !== 32'h48) begin n_fail++; $display("FAIL ovf_clear: got %08h, required 00000048", r); end
  endtask

  task automatic test_full_push_pop();
    int unsigned e0, ign, t_pop;
    logic [31:0] r;
    wb_write(A_HOLD, 32'd20, 4'hF, ign);
    wb_write(A_CTRL, 32'h3, 4'h1, e0);
    t_pop = e0 + 21;
    fork
      begin : mon
        logic [7:0]  prev, exp_v;
        int unsigned exp_t;
        bit          got;
        prev = io_out;
        for (int k = 0; k < 10; k++) begin
          exp_t = (k == 0) ? e0 + 1 : t_pop + k - 1;
          got   = 1'b0;
          for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (io_out !== prev) begin got = 1'b1; break; end
          end
          n_chk++;
          if (!got) begin n_fail++; $display("FAIL fpp_timeout: pattern %0d never appeared, io_out stuck at %02h", k, io_out); break; end
          prev  = io_out;
          exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
          if (io_out !== exp_v) begin n_fail++; $display("FAIL fpp_value: pattern %0d got %02h, required %02h", k, io_out, exp_v); end
          n_chk++;
          if (cyc_cnt != exp_t) begin n_fail++; $display("FAIL fpp_time: pattern %0d at cycle %0d, required %0d", k, cyc_cnt, exp_t); end
        end
      end
      begin : bus
        int unsigned e1;
        exp_q.push_back(8'h50);
        wb_write(A_DATA, 32'h50, 4'h1, ign);
        wb_write(A_HOLD, 32'd1, 4'hF, ign);
        while (cyc_cnt < t_pop - 2) @(negedge clk);
        exp_q.push_back(8'h51);
        wb_write(A_DATA, 32'h51, 4'h1, e1);
        n_chk++; if (e1 != t_pop) begin n_fail++; $display("FAIL fpp_push_cycle: sampled at %0d, required %0d", e1, t_pop); end
        wb_read(A_STAT, r);
        n_chk++; if (r !== 32'h87) begin n_fail++; $display("FAIL fpp_status: got %08h, required 00000087", r); end
      end
    join
    wb_read(A_STAT, r);
    n_chk++; if (r !== 32'h20) begin n_fail++; $display("FAIL fpp_drain_status: got %08h, required 00000020", r); end
  endtask

  task automatic test_flush_and_reset();
    int unsigned e0, ign;
    logic [31:0] r;
    logic [7:0]  prev, exp_v;
    bit          got;
    wb_write(A_CTRL, 32'h2, 4'h1, ign);
    wb_write(A_HOLD, 32'd10, 4'hF, ign);
    exp_q.push_back(8'h61);
    for (int i = 0; i < 3; i++) wb_write(A_DATA, 32'(8'h61 + i), 4'h1, ign);
    wb_write(A_CTRL, 32'h3, 4'h1, e0);
    prev = io_out;
    got  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (io_out !== prev) begin got = 1'b1; break; end
    end
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    n_chk++;
    if (!got || io_out !== exp_v || cyc_cnt != e0 + 1) begin
      n_fail++;
      $display("FAIL flush_first: got %02h at cycle %0d, required %02h at %0d", io_out, cyc_cnt, exp_v, e0 + 1);
    end
    repeat (2) @(negedge clk);
    wb_write(A_CTRL, 32'h7, 4'h1, ign);
    wb_read(A_STAT, r);
    n_chk++; if (r !== 32'h20) begin n_fail++; $display("FAIL flush_status: got %08h, required 00000020", r); end
    wb_read(A_CTRL, r);
    n_chk++; if (r !== 32'h3) begin n_fail++; $display("FAIL flush_ctrl_read: got %08h, required 00000003", r); end
    repeat (15) @(negedge clk);
    n_chk++; if (io_out !== 8'h61) begin n_fail++; $display("FAIL flush_hold: got %02h, required 61", io_out); end
    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++; if (io_out !== 8'h00) begin n_fail++; $display("FAIL async_rst_io_out: got %02h, required 00", io_out); end
    n_chk++; if (io_oeb !== 8'hFF) begin n_fail++; $display("FAIL async_rst_io_oeb: got %02h, required FF", io_oeb); end
    @(negedge clk);
    rst = 1'b0;
    wb_read(A_STAT, r);
    n_chk++; if (r !== 32'h20) begin n_fail++; $display("FAIL post_rst_status: got %08h, required 00000020", r); end
    wb_read(A_HOLD, r);
    n_chk++; if (r !== 32'h1) begin n_fail++; $display("FAIL post_rst_hold: got %08h, required 00000001", r); end
    wb_read(A_CTRL, r);
    n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL post_rst_ctrl: got %08h, required 00000000", r); end
  endtask

  initial begin
    rst  = 1'b1;
    cyc  = 1'b0;
    stb  = 1'b0;
    we   = 1'b0;
    sel  = 4'h0;
    adr  = 32'h0;
    wdat = 32'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_flush_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
